// File: rtl/ppu_write_queue.sv
// Write buffer in front of the PPU bus port: queues host table writes and replays them only during vblank.
// Optional status word (fill level, dropped-write count) enabled by defining PPU_WQ_STATUS_EN.
module ppu_write_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = 12,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vblank,
  input  logic          host_chipselect,
  input  logic          host_write,
  input  logic          host_read,
  input  logic [AW-1:0] host_address,
  input  logic [DW-1:0] host_writedata,
  output logic [31:0]   host_readdata,
  output logic          ppu_chipselect,
  output logic          ppu_write,
  output logic [AW-1:0] ppu_address,
  output logic [DW-1:0] ppu_writedata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head, tail, head_next;
  logic [CNT_W-1:0] count;
  state_t           state, next_state;

  logic [1:0]    table_sel;
  logic          host_wr, push_req, push_ok, pop, full;
  logic          ppu_chipselect_d, ppu_write_d;
  logic [AW-1:0] ppu_address_d;
  logic [DW-1:0] ppu_writedata_d;
  entry_t        head_entry;

  assign table_sel = host_address[AW-1 -: 2];
  assign host_wr   = host_chipselect & host_write;
  assign push_req  = host_wr && (table_sel != 2'b11);
  assign pop       = (state == HOLD);
  assign full      = (count == CNT_W'(DEPTH));
  // A pop in the same cycle frees the slot, so a push on a full queue is still accepted.
  assign push_ok   = push_req && (!full || pop);

  // NOTE: queue storage carries no reset; only pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[tail] <= '{addr: host_address, data: host_writedata};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= tail + PTR_W'(1);
      if (pop)     head <= head + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop);
    end
  end

  assign head_next  = pop ? head + PTR_W'(1) : head;
  assign head_entry = mem[head_next];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (vblank && count != '0) next_state = ISSUE;
      ISSUE:   next_state = HOLD;
      // Continuation is judged on the entries left after this pop, not on a concurrent push.
      HOLD:    next_state = (vblank && count > CNT_W'(1)) ? ISSUE : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from next_state so the registered ppu_* signals line up with the state.
  always_comb begin
    ppu_chipselect_d = 1'b0;
    ppu_write_d      = 1'b0;
    ppu_address_d    = '0;
    ppu_writedata_d  = '0;
    unique case (next_state)
      ISSUE: begin
        ppu_chipselect_d = 1'b1;
        ppu_write_d      = 1'b1;
        ppu_address_d    = head_entry.addr;
        ppu_writedata_d  = head_entry.data;
      end
      HOLD: begin
        ppu_write_d     = 1'b1;
        ppu_address_d   = ppu_address;
        ppu_writedata_d = ppu_writedata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      ppu_chipselect <= 1'b0;
      ppu_write      <= 1'b0;
      ppu_address    <= '0;
      ppu_writedata  <= '0;
    end else begin
      state          <= next_state;
      ppu_chipselect <= ppu_chipselect_d;
      ppu_write      <= ppu_write_d;
      ppu_address    <= ppu_address_d;
      ppu_writedata  <= ppu_writedata_d;
    end
  end

`ifdef PPU_WQ_STATUS_EN
  logic [7:0]  overflow_cnt;
  logic        clr_req, drop, empty;
  logic [4:0]  count5;
  logic [31:0] status_word;

  assign clr_req     = host_wr && (table_sel == 2'b11);
  assign drop        = push_req && !push_ok;
  assign empty       = (count == '0);
  assign count5      = 5'(count);
  assign status_word = {16'b0, overflow_cnt, 1'b0, full, empty, count5};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_cnt  <= '0;
      host_readdata <= '0;
    end else begin
      if (clr_req)                           overflow_cnt <= '0;
      else if (drop && overflow_cnt != 8'hFF) overflow_cnt <= overflow_cnt + 8'd1;
      if (host_chipselect && host_read) host_readdata <= status_word;
    end
  end
`else
  logic unused_host_read;
  assign unused_host_read = host_read;
  assign host_readdata    = '0;
`endif

endmodule

// File: tb/tb_ppu_write_queue.sv
// Self-checking bench for ppu_write_queue: directed table, hand sequences for corner cases,
// and randomized traffic checked each cycle against a transaction-level queue model.
module tb_ppu_write_queue;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        vblank, host_chipselect, host_write, host_read;
  logic [11:0] host_address;
  logic [31:0] host_writedata;
  logic [31:0] host_readdata;
  logic        ppu_chipselect, ppu_write;
  logic [11:0] ppu_address;
  logic [31:0] ppu_writedata;

  always #5 clk = ~clk;

  ppu_write_queue #(.DEPTH(DEPTH), .AW(12), .DW(32)) dut (
    .clk(clk), .reset(reset), .vblank(vblank),
    .host_chipselect(host_chipselect), .host_write(host_write), .host_read(host_read),
    .host_address(host_address), .host_writedata(host_writedata), .host_readdata(host_readdata),
    .ppu_chipselect(ppu_chipselect), .ppu_write(ppu_write),
    .ppu_address(ppu_address), .ppu_writedata(ppu_writedata)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_issue = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: pending entries in arrival order, plus cycles left in the current two-cycle transfer.
  typedef struct packed { logic [11:0] a; logic [31:0] d; } ent_t;
  ent_t        q[$];
  int          busy;
  logic [7:0]  m_ovf;
  logic [31:0] m_rd;

  task automatic model_reset();
    q.delete();
    busy  = 0;
    m_ovf = 8'd0;
    m_rd  = 32'd0;
  endtask

  task automatic model_check();
    check("ppu_chipselect", ppu_chipselect, busy == 2);
    check("ppu_write", ppu_write, busy != 0);
    if (busy != 0) begin
      check("ppu_address", ppu_address, q[0].a);
      check("ppu_writedata", ppu_writedata, q[0].d);
    end
    check("host_readdata", host_readdata, m_rd);
    if (ppu_chipselect === 1'b1) n_issue++;
  endtask

  task automatic model_update();
    bit is_clr, is_push, pop;
    int sz, nb;
    is_clr  = host_chipselect && host_write && host_address[11:10] == 2'b11;
    is_push = host_chipselect && host_write && !is_clr;
    pop     = (busy == 1);
    sz      = q.size();
`ifdef PPU_WQ_STATUS_EN
    if (host_chipselect && host_read)
      m_rd = {16'b0, m_ovf, 1'b0, sz == DEPTH, sz == 0, 5'(sz)};
`endif
    if (busy == 2)      nb = 1;
    else if (busy == 1) nb = (vblank && sz > 1) ? 2 : 0;
    else                nb = (vblank && sz > 0) ? 2 : 0;
    if (pop) void'(q.pop_front());
    if (is_clr) m_ovf = 8'd0;
    else if (is_push) begin
      if (sz < DEPTH || pop) q.push_back('{a: host_address, d: host_writedata});
      else if (m_ovf != 8'hFF) m_ovf++;
    end
    busy = nb;
  endtask

  // Called at a falling edge with inputs set; checks, advances one clock, returns at the next falling edge.
  task automatic step();
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clear_host();
    host_chipselect = 1'b0;
    host_write      = 1'b0;
    host_read       = 1'b0;
  endtask

  task automatic push(input logic [11:0] a, input logic [31:0] d);
    host_chipselect = 1'b1;
    host_write      = 1'b1;
    host_address    = a;
    host_writedata  = d;
    step();
    clear_host();
  endtask

  task automatic status_read(input string name, input logic [31:0] exp);
    host_chipselect = 1'b1;
    host_read       = 1'b1;
    step();
    clear_host();
    check(name, host_readdata, exp);
  endtask

  task automatic wait_busy(input int target, input int max_cycles);
    int n = 0;
    while (busy != target && n < max_cycles) begin
      step();
      n++;
    end
    if (busy != target) begin
      n_total++;
      $display("FAIL wait_busy: transfer phase %0d not reached within %0d cycles", target, max_cycles);
    end
  endtask

  typedef struct {
    logic        vb, wr;
    logic [11:0] a;
    logic [31:0] d;
    logic        e_cs, e_wr;
    logic [11:0] e_a;
    logic [31:0] e_d;
  } vec_t;
  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 12'h005, 32'hAAAA0001, 1'b0, 1'b0, 12'h000, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 12'h402, 32'h12345678, 1'b0, 1'b0, 12'h000, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 12'h80F, 32'h00FF00FF, 1'b0, 1'b0, 12'h000, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 12'h000, 32'h0,        1'b0, 1'b0, 12'h000, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 12'h000, 32'h0,        1'b1, 1'b1, 12'h005, 32'hAAAA0001};
    tbl[5]  = '{1'b1, 1'b0, 12'h000, 32'h0,        1'b0, 1'b1, 12'h005, 32'hAAAA0001};
    tbl[6]  = '{1'b1, 1'b0, 12'h000, 32'h0,        1'b1, 1'b1, 12'h402, 32'h12345678};
    tbl[7]  = '{1'b1, 1'b0, 12'h000, 32'h0,        1'b0, 1'b1, 12'h402, 32'h12345678};
    tbl[8]  = '{1'b1, 1'b0, 12'h000, 32'h0,        1'b1, 1'b1, 12'h80F, 32'h00FF00FF};
    tbl[9]  = '{1'b1, 1'b0, 12'h000, 32'h0,        1'b0, 1'b1, 12'h80F, 32'h00FF00FF};
    tbl[10] = '{1'b1, 1'b0, 12'h000, 32'h0,        1'b0, 1'b0, 12'h000, 32'h0};
    tbl[11] = '{1'b0, 1'b0, 12'h000, 32'h0,        1'b0, 1'b0, 12'h000, 32'h0};

    reset          = 1'b1;
    vblank         = 1'b0;
    host_address   = '0;
    host_writedata = '0;
    clear_host();
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_cs", ppu_chipselect, 1'b0);
    check("reset_wr", ppu_write, 1'b0);
    check("reset_addr", ppu_address, 12'h000);
    check("reset_data", ppu_writedata, 32'h0);
    check("reset_rd", host_readdata, 32'h0);
    reset = 1'b0;

    // Three writes held off until vblank, then six cycles of output in order.
    for (int i = 0; i < 12; i++) begin
      vblank          = tbl[i].vb;
      host_chipselect = tbl[i].wr;
      host_write      = tbl[i].wr;
      host_address    = tbl[i].a;
      host_writedata  = tbl[i].d;
      check($sformatf("tbl%0d_cs", i), ppu_chipselect, tbl[i].e_cs);
      check($sformatf("tbl%0d_wr", i), ppu_write, tbl[i].e_wr);
      if (tbl[i].e_wr) begin
        check($sformatf("tbl%0d_addr", i), ppu_address, tbl[i].e_a);
        check($sformatf("tbl%0d_data", i), ppu_writedata, tbl[i].e_d);
      end
      step();
    end
    clear_host();

    // Overfill: 20 pushes into 16 slots, then clear the drop counter and drain.
    vblank = 1'b0;
    for (int i = 0; i < 20; i++) push(12'((i % 3) << 10) | 12'(i), $urandom);
`ifdef PPU_WQ_STATUS_EN
    status_read("status_full", 32'h0000_0450);
`endif
    push(12'hC00, 32'h0);
`ifdef PPU_WQ_STATUS_EN
    status_read("status_cleared", 32'h0000_0050);
`endif
    n_issue = 0;
    vblank  = 1'b1;
    repeat (40) step();
    check("drain16_count", n_issue, 16);
    vblank = 1'b0;

    // Full queue: push lands on the HOLD pop, vblank ends there, queue stays full.
    for (int i = 0; i < 16; i++) push(12'h100 + 12'(i), $urandom);
    vblank = 1'b1;
    wait_busy(1, 10);
    host_chipselect = 1'b1;
    host_write      = 1'b1;
    host_address    = 12'h9AB;
    host_writedata  = 32'hCAFE_F00D;
    vblank          = 1'b0;
    step();
    clear_host();
    repeat (2) step();
    check("hold_push_idle_cs", ppu_chipselect, 1'b0);
`ifdef PPU_WQ_STATUS_EN
    status_read("status_hold_push", 32'h0000_0050);
`endif
    push(12'h0EE, 32'hDEAD_BEEF);
`ifdef PPU_WQ_STATUS_EN
    status_read("status_drop1", 32'h0000_0150);
`endif
    n_issue = 0;
    vblank  = 1'b1;
    repeat (40) step();
    check("drain_after_hold_push", n_issue, 16);

    // Clear-address write: not enqueued, no PPU traffic, counter cleared.
    push(12'hC05, 32'h5555_5555);
    repeat (4) step();
`ifdef PPU_WQ_STATUS_EN
    status_read("status_after_c05", 32'h0000_0020);
`endif
    vblank = 1'b0;

    // vblank drops during ISSUE of entry 2 of 5; the remaining three replay next vblank.
    for (int i = 0; i < 5; i++) push(12'h200 + 12'(i), 32'h1000 + 32'(i));
    n_issue = 0;
    vblank  = 1'b1;
    wait_busy(2, 10);
    step();
    step();
    vblank = 1'b0;
    repeat (6) step();
    check("split_issued", n_issue, 2);
`ifdef PPU_WQ_STATUS_EN
    status_read("status_split", 32'h0000_0003);
`endif
    n_issue = 0;
    vblank  = 1'b1;
    repeat (10) step();
    check("split_resume", n_issue, 3);
    vblank = 1'b0;

    // Reset in the middle of HOLD clears outputs without waiting for a clock.
    for (int i = 0; i < 3; i++) push(12'h300 + 12'(i), $urandom);
    vblank = 1'b1;
    wait_busy(1, 10);
    reset = 1'b1;
    #1;
    check("async_rst_wr", ppu_write, 1'b0);
    check("async_rst_cs", ppu_chipselect, 1'b0);
    check("async_rst_addr", ppu_address, 12'h000);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("rst_readdata", host_readdata, 32'h0);
    repeat (4) step();
`ifdef PPU_WQ_STATUS_EN
    status_read("status_after_rst", 32'h0000_0020);
`endif

    // Randomized traffic across vblank windows, all checked by the model.
    vblank = 1'b0;
    for (int i = 0; i < 900; i++) begin
      int r;
      if ($urandom_range(39) == 0) vblank = ~vblank;
      r = $urandom_range(9);
      if (r < 4) begin
        host_chipselect = 1'b1;
        host_write      = 1'b1;
        host_address    = {($urandom_range(19) == 0) ? 2'b11 : 2'($urandom_range(2)), 10'($urandom)};
        host_writedata  = $urandom;
      end else if (r == 9) begin
        host_chipselect = 1'b1;
        host_read       = 1'b1;
      end
      step();
      clear_host();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
